// File: rtl/oes_pkg.sv
// Shared definitions for the odd-even transposition sorter: mode flag values,
// stage phase encoding and a lane-offset helper for the packed vector.
package oes_pkg;

   localparam logic MODE_ASC  = 1'b0;
   localparam logic MODE_DESC = 1'b1;

   typedef enum logic {
      PHASE_EVEN = 1'b0,
      PHASE_ODD  = 1'b1
   } phase_e;

   // Bit offset of a lane inside the packed vector (lane 0 at the LSB).
   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/oes_stage.sv
// One column of compare-exchange cells followed by the stage register.
// Even phase pairs lanes (0,1),(2,3)...; odd phase pairs (1,2),(3,4)...
module oes_stage
   import oes_pkg::*;
#(
   parameter int     N     = 8,
   parameter int     M     = 4,
   parameter phase_e PHASE = PHASE_EVEN
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         valid_d,
   input  logic         desc_d,
   input  logic [M*N-1:0] data_d,
   output logic         valid_q,
   output logic         desc_q,
   output logic [M*N-1:0] data_q
);

   localparam int unsigned FIRST = (PHASE == PHASE_EVEN) ? 0 : 1;

   logic [M*N-1:0] data_x;
   logic [N-1:0]   lo;
   logic [N-1:0]   hi;
   logic           swap;

   // Strict compare so equal lanes never swap; the mode is the one that
   // travelled with this vector, not a global setting.
   always_comb begin
      data_x = data_d;
      lo     = '0;
      hi     = '0;
      swap   = 1'b0;
      for (int unsigned a = FIRST; a + 1 < M; a += 2) begin
         lo   = data_d[lane_lsb(a, N) +: N];
         hi   = data_d[lane_lsb(a + 1, N) +: N];
         swap = (desc_d == MODE_DESC) ? (lo < hi) : (lo > hi);
         if (swap) begin
            data_x[lane_lsb(a, N) +: N]     = hi;
            data_x[lane_lsb(a + 1, N) +: N] = lo;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         desc_q  <= 1'b0;
         data_q  <= '0;
      end else if (en) begin
         valid_q <= valid_d;
         desc_q  <= desc_d;
         data_q  <= data_x;
      end
   end

endmodule

// File: rtl/odd_even_sort_pipe.sv
// M-stage registered odd-even transposition sorter with valid/ready handshake
// and a per-vector ascending/descending flag. The whole pipe stalls as one.
module odd_even_sort_pipe
   import oes_pkg::*;
#(
   parameter int N = 8,
   parameter int M = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           in_desc,
   input  logic [M*N-1:0] in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           out_desc,
   output logic [M*N-1:0] out_data
);

   logic           en;
   logic [M:0]     valid_s;
   logic [M:0]     desc_s;
   logic [M*N-1:0] data_s [M+1];

   // Global advance: bubbles are not squeezed out, so a stalled output
   // freezes every stage including empty ones.
   assign en       = ~rst & (~out_valid | out_ready);
   assign in_ready = en;

   assign valid_s[0] = in_valid & in_ready;
   assign desc_s[0]  = in_desc;
   assign data_s[0]  = in_data;

   for (genvar k = 0; k < M; k++) begin : g_stage
      oes_stage #(
         .N     (N),
         .M     (M),
         .PHASE ((k % 2 == 0) ? PHASE_EVEN : PHASE_ODD)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .en      (en),
         .valid_d (valid_s[k]),
         .desc_d  (desc_s[k]),
         .data_d  (data_s[k]),
         .valid_q (valid_s[k+1]),
         .desc_q  (desc_s[k+1]),
         .data_q  (data_s[k+1])
      );
   end

   assign out_valid = valid_s[M];
   assign out_desc  = desc_s[M];
   assign out_data  = data_s[M];

endmodule

// File: tb/tb_odd_even_sort_pipe.sv
// Directed bench for odd_even_sort_pipe (M=4, N=8): table of hand-sorted
// vectors plus sequences for latency, streaming, backpressure and reset.
module tb_odd_even_sort_pipe;

   localparam int N = 8;
   localparam int M = 4;
   localparam int W = M * N;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic         in_desc;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic         out_desc;
   logic [W-1:0] out_data;

   odd_even_sort_pipe #(.N(N), .M(M)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_desc   (in_desc),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_desc  (out_desc),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] din;
      logic         desc;
      logic [W-1:0] dexp;
   } vec_t;

   vec_t tbl [9];
   int   checks = 0;
   int   passed = 0;

   function automatic logic [W-1:0] pk(input logic [7:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic check_int(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // One vector alone through an empty pipe; measures edges to out_valid.
   task automatic send_single(input int idx);
      int n;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_desc   = tbl[idx].desc;
      in_data   = tbl[idx].din;
      #2;
      check_int($sformatf("single%0d_in_ready", idx), int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = '0;
      in_desc  = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check_int($sformatf("single%0d_latency", idx), n, M);
      check($sformatf("single%0d_data", idx), out_data, tbl[idx].dexp);
      check_int($sformatf("single%0d_desc", idx), int'(out_desc), int'(tbl[idx].desc));
      @(posedge clk); #1;
      check_int($sformatf("single%0d_retired", idx), int'(out_valid), 0);
   endtask

   // Streams cnt table vectors from index first; out_ready low for stall_len
   // cycles starting at cycle stall_at. Drives and samples in one process.
   task automatic run_stream(input string nm, input int first, input int cnt,
                             input int stall_at, input int stall_len);
      int   sent = 0;
      int   rx = 0;
      int   first_rx = -1;
      int   last_rx = -1;
      int   stalls = 0;
      logic acc;
      for (int c = 0; c < 80 && rx < cnt; c++) begin
         out_ready = !(c >= stall_at && c < stall_at + stall_len);
         if (sent < cnt) begin
            in_valid = 1'b1;
            in_desc  = tbl[first+sent].desc;
            in_data  = tbl[first+sent].din;
         end else begin
            in_valid = 1'b0;
            in_desc  = 1'b0;
            in_data  = '0;
         end
         #2;
         if (out_valid && !out_ready) begin
            stalls++;
            check({nm, "_stall_in_ready"}, W'(in_ready), W'(0));
            check({nm, "_stall_hold"}, out_data, tbl[first+rx].dexp);
         end
         if (out_valid && out_ready) begin
            check($sformatf("%s_data%0d", nm, rx), out_data, tbl[first+rx].dexp);
            check_int($sformatf("%s_desc%0d", nm, rx), int'(out_desc), int'(tbl[first+rx].desc));
            if (first_rx < 0) first_rx = c;
            last_rx = c;
            rx++;
         end
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) sent++;
      end
      in_valid  = 1'b0;
      in_data   = '0;
      in_desc   = 1'b0;
      out_ready = 1'b1;
      #2;
      check_int({nm, "_rx_count"}, rx, cnt);
      check_int({nm, "_sent_count"}, sent, cnt);
      check_int({nm, "_stall_cycles"}, stalls, stall_len);
      check_int({nm, "_first_out_cycle"}, first_rx, M);
      check_int({nm, "_last_out_cycle"}, last_rx, cnt - 1 + M + stall_len);
      check_int({nm, "_drained"}, int'(out_valid), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int seen;

      tbl[0] = '{pk(8'h40, 8'h03, 8'hFF, 8'h10), 1'b0, pk(8'h03, 8'h10, 8'h40, 8'hFF)};
      tbl[1] = '{pk(8'h05, 8'h05, 8'h00, 8'h80), 1'b1, pk(8'h80, 8'h05, 8'h05, 8'h00)};
      tbl[2] = '{pk(8'hFF, 8'hFE, 8'h01, 8'h00), 1'b0, pk(8'h00, 8'h01, 8'hFE, 8'hFF)};
      tbl[3] = '{pk(8'h12, 8'h34, 8'h56, 8'h78), 1'b1, pk(8'h78, 8'h56, 8'h34, 8'h12)};
      tbl[4] = '{pk(8'h78, 8'h56, 8'h34, 8'h12), 1'b0, pk(8'h12, 8'h34, 8'h56, 8'h78)};
      tbl[5] = '{pk(8'hAA, 8'h00, 8'hAA, 8'h01), 1'b1, pk(8'hAA, 8'hAA, 8'h01, 8'h00)};
      tbl[6] = '{pk(8'h09, 8'h08, 8'h07, 8'h06), 1'b0, pk(8'h06, 8'h07, 8'h08, 8'h09)};
      tbl[7] = '{pk(8'h00, 8'h00, 8'h00, 8'h00), 1'b1, pk(8'h00, 8'h00, 8'h00, 8'h00)};
      tbl[8] = '{pk(8'h7F, 8'h80, 8'h01, 8'hFE), 1'b0, pk(8'h01, 8'h7F, 8'h80, 8'hFE)};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_desc   = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;

      // Reset and idle
      repeat (3) @(posedge clk);
      #1;
      check_int("rst_in_ready_low", int'(in_ready), 0);
      rst = 1'b0;
      #1;
      check_int("idle_out_valid", int'(out_valid), 0);
      check("idle_out_data", out_data, '0);
      check_int("idle_out_desc", int'(out_desc), 0);
      check_int("idle_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;

      // Single vectors: ascending, descending with ties, reversed input
      send_single(0);
      send_single(1);
      send_single(2);

      // Back-to-back alternating modes
      run_stream("b2b", 3, 6, 1000, 0);

      // Backpressure mid-stream
      run_stream("bp", 0, 8, 5, 5);

      // Reset with three vectors in flight
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_desc  = tbl[i].desc;
         in_data  = tbl[i].din;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_data  = '0;
      in_desc  = 1'b0;
      rst      = 1'b1;
      #2;
      check_int("midrst_in_ready_low", int'(in_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      check_int("midrst_out_valid", int'(out_valid), 0);
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         #2;
         if (out_valid) seen++;
         @(posedge clk); #1;
      end
      check_int("midrst_no_leak", seen, 0);
      send_single(8);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/odd_even_sort_pipe.md
Name: odd_even_sort_pipe

Overview:
- Parametrised successor to the fixed 4-input compare-exchange sorter.
- Sorts M unsigned N-bit lanes with an M-stage registered odd-even transposition network.
- Adds a valid/ready handshake with global backpressure and a per-vector ascending/descending mode flag.
- Sits between a vector producer and a consumer; accepts one vector per cycle when not stalled.

Parameters:
- N, 8, lane width in bits.
- M, 4, lane count; must be even and at least 2. Pipeline depth equals M.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input vector present.
- in_ready  output  1  block accepts the input vector this cycle.
- in_desc  input  1  0 = ascending, 1 = descending; sampled together with in_data.
- in_data  input  M*N  lane i occupies bits [i*N +: N]; lane 0 at the LSB.
- out_valid  output  1  sorted vector present.
- out_ready  input  1  consumer accepts the output vector this cycle.
- out_desc  output  1  mode flag that travelled with the vector.
- out_data  output  M*N  sorted vector, same lane packing as in_data.

Behaviour:
- Reset: rst high at a rising edge clears every stage's valid, desc and data registers to 0. After that edge out_valid=0, out_data=0 and out_desc=0.
- in_ready is combinational: 0 while rst=1, otherwise (~out_valid | out_ready).
- Reset mid-operation discards all in-flight vectors. No partial output appears.
- Advance enable: en = ~rst & (~out_valid | out_ready). When en=1, every stage register loads from its predecessor. When en=0, every stage register holds.
- Bubbles do not collapse: an empty stage ahead of a stalled output still holds.
- Stage 0 loads {in_valid & in_ready, in_desc, in_data}. in_valid=0 injects a bubble with valid=0.
- Stage k (k = 0..M-1) compares lane pairs:
  - k even: pairs (0,1), (2,3), …, (M-2, M-1).
  - k odd: pairs (1,2), (3,4), …, (M-3, M-2). Lanes 0 and M-1 pass through unchanged.
- Compare-exchange for pair (a, b) with a < b:
  - Ascending: lane a receives min, lane b receives max.
  - Descending: lane a receives max, lane b receives min.
  - Comparison is unsigned, full N bits.
  - Equal values pass through without swapping; the swap condition is strict.
- Each stage uses the desc bit registered alongside its own data, so vectors of mixed modes may be in flight back to back.
- Latency: a vector accepted at edge t appears at out_valid/out_data after edge t+M, assuming no stalls. Each stall cycle adds one cycle.
- Throughput: one vector per cycle while out_ready=1.
- Output handshake: the vector completes when out_valid & out_ready. While out_valid=1 and out_ready=0, out_data and out_desc are held stable.
- Simultaneous in_valid and out_ready with a full pipeline: the output retires and the input is accepted in the same cycle.
- Invalid stages still shift their data, but their contents are don't-care and are never observed because out_valid gates them.

Decomposition:
- Package oes_pkg holds:
  - Constants MODE_ASC=1'b0 and MODE_DESC=1'b1.
  - A lane-extract helper (index into the packed vector).
  - The PHASE_EVEN/PHASE_ODD encoding.
- Sub-module oes_stage, parameters N, M and PHASE:
  - One column of compare-exchange cells plus the valid/desc/data register, gated by en.
  - odd_even_sort_pipe instantiates M of these in a generate loop, with PHASE alternating.

Test Plan:
- Reset and idle: hold rst for 3 cycles, then release. Required: out_valid=0, out_data=0 and in_ready=1 on the first cycle after release.
- Single ascending vector (M=4, N=8): lanes 0..3 = {0x40, 0x03, 0xFF, 0x10}, in_desc=0, out_ready=1. Required: out_valid rises exactly 4 cycles later with lanes {0x03, 0x10, 0x40, 0xFF} and out_desc=0.
- Descending and ties: lanes {0x05, 0x05, 0x00, 0x80}, in_desc=1. Required: lanes {0x80, 0x05, 0x05, 0x00}. Then send reversed input {0xFF, 0xFE, 0x01, 0x00} ascending. Required: {0x00, 0x01, 0xFE, 0xFF}, which exercises the worst case across all M stages.
- Back-to-back mixed modes: 6 consecutive vectors with alternating in_desc and out_ready=1. Required: 6 consecutive out_valid cycles, each correctly sorted, with out_desc matching its input.
- Backpressure: stream 8 vectors and drop out_ready for 5 cycles mid-stream. Required:
  - in_ready=0 whenever out_valid=1 and out_ready=0.
  - out_data stays stable throughout the stall.
  - All 8 vectors arrive in order with no loss or duplication.
- Reset mid-stream: assert rst for 1 cycle with 3 vectors in flight. Required: out_valid=0 the next cycle, none of those vectors emerge, and a new vector sent afterwards emerges correctly after 4 cycles.
